pc_next_unit: RTL and testbench

Parametrised program-counter and next-PC selection unit for the MIPS fetch stage, replacing the fixed 32-bit branch-only PC adder. Holds the PC register and selects the next PC from sequential, conditional branch (BEQ/BNE), J/JAL, JR and exception redirects. A fetch stall freezes the PC. Any redirect that arrives during a stall is buffered and applied once the stall releases.

---
 rtl/pc_next_unit_pkg.sv | 21 ++
 rtl/pc_next_unit_if.sv | 39 +++
 rtl/pc_next_unit_target_calc.sv | 32 +++
 rtl/pc_next_unit.sv | 124 ++++++++++++
 tb/tb_pc_next_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/pc_next_unit_pkg.sv
// Shared types and constants for the fetch-stage next-PC unit.
// Imported by the target calculator and the top level.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_BR,
    PC_J,
    PC_JR,
    PC_EXC,
    PC_PEND
  } pc_sel_e;

  typedef enum logic {
    RUN,
    HELD
  } pc_state_e;

  localparam int PC_INCR = 4;

endpackage

// File: rtl/pc_next_unit_if.sv
// Fetch-control bundle between decode/trap logic and the PC unit.
// The master side drives redirect requests; the slave side owns the PC.
interface pc_next_unit_if #(
  parameter int XLEN = 32
);

  logic            stall;
  logic            branch;
  logic            branch_ne;
  logic            zero;
  logic [XLEN-1:0] imm_ext;
  logic            jump;
  logic [25:0]     jump_target;
  logic            jump_reg;
  logic [XLEN-1:0] rs_value;
  logic            exception;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus_4;
  logic [XLEN-1:0] epc;
  logic            redirect_taken;
  logic            pending;

  modport master (
    output stall, branch, branch_ne, zero,
    output imm_ext, jump, jump_target,
    output jump_reg, rs_value, exception,
    input  pc, pc_plus_4, epc,
    input  redirect_taken, pending
  );

  modport slave (
    input  stall, branch, branch_ne, zero,
    input  imm_ext, jump, jump_target,
    input  jump_reg, rs_value, exception,
    output pc, pc_plus_4, epc,
    output redirect_taken, pending
  );

endinterface

// File: rtl/pc_next_unit_target_calc.sv
// Combinational branch/jump/JR target arithmetic.
// All sums wrap modulo 2^XLEN.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_ext_i,
  input  logic [XLEN-1:0] rs_value_i,
  input  logic [25:0]     jump_target_i,
  input  logic            branch_i,
  input  logic            branch_ne_i,
  input  logic            zero_i,
  output logic [XLEN-1:0] pc_plus_4_o,
  output logic [XLEN-1:0] br_tgt_o,
  output logic [XLEN-1:0] j_tgt_o,
  output logic [XLEN-1:0] jr_tgt_o,
  output logic            br_taken_o
);

  localparam logic [XLEN-1:0] WORD_MASK =
    {{(XLEN-2){1'b1}}, 2'b00};

  assign pc_plus_4_o = pc_i + XLEN'(PC_INCR);
  assign br_tgt_o    = pc_plus_4_o + (imm_ext_i << 2);
  assign j_tgt_o     = {pc_plus_4_o[XLEN-1:28],
                        jump_target_i, 2'b00};
  assign jr_tgt_o    = rs_value_i & WORD_MASK;
  assign br_taken_o  = branch_i & (zero_i ^ branch_ne_i);

endmodule

// File: rtl/pc_next_unit.sv
// PC register with next-PC priority mux and stall-time
// redirect buffering; exceptions override everything.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] EXC_VECTOR   = 'h180
) (
  input logic          clk,
  input logic          rst,
  pc_next_unit_if.slave bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            pend_q, pend_d;
  logic            rt_q, rt_d;
  pc_state_e       st_q, st_d;

  logic [XLEN-1:0] pp4, br_tgt, j_tgt, jr_tgt;
  logic [XLEN-1:0] sel_tgt;
  logic            br_taken;
  pc_sel_e         sel;

  pc_target_calc #(
    .XLEN(XLEN)
  ) u_calc (
    .pc_i          (pc_q),
    .imm_ext_i     (bus.imm_ext),
    .rs_value_i    (bus.rs_value),
    .jump_target_i (bus.jump_target),
    .branch_i      (bus.branch),
    .branch_ne_i   (bus.branch_ne),
    .zero_i        (bus.zero),
    .pc_plus_4_o   (pp4),
    .br_tgt_o      (br_tgt),
    .j_tgt_o       (j_tgt),
    .jr_tgt_o      (jr_tgt),
    .br_taken_o    (br_taken)
  );

  // While HELD the buffered redirect masks all new requests.
  always_comb begin
    sel = PC_SEQ;
    if (bus.exception)       sel = PC_EXC;
    else if (st_q == HELD)   sel = PC_PEND;
    else if (bus.jump_reg)   sel = PC_JR;
    else if (bus.jump)       sel = PC_J;
    else if (br_taken)       sel = PC_BR;
  end

  always_comb begin
    sel_tgt = pp4;
    unique case (sel)
      PC_SEQ:  sel_tgt = pp4;
      PC_BR:   sel_tgt = br_tgt;
      PC_J:    sel_tgt = j_tgt;
      PC_JR:   sel_tgt = jr_tgt;
      PC_EXC:  sel_tgt = EXC_VECTOR;
      PC_PEND: sel_tgt = tgt_q;
      default: sel_tgt = pp4;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    epc_d  = epc_q;
    tgt_d  = tgt_q;
    pend_d = pend_q;
    st_d   = st_q;
    rt_d   = 1'b0;
    unique case (1'b1)
      bus.exception: begin
        pc_d   = EXC_VECTOR;
        epc_d  = pc_q;
        pend_d = 1'b0;
        st_d   = RUN;
        rt_d   = 1'b1;
      end
      !bus.exception && !bus.stall: begin
        pc_d = sel_tgt;
        rt_d = (sel != PC_SEQ);
        if (st_q == HELD) begin
          pend_d = 1'b0;
          st_d   = RUN;
        end
      end
      !bus.exception && bus.stall &&
      (st_q == RUN) && (sel != PC_SEQ): begin
        tgt_d  = sel_tgt;
        pend_d = 1'b1;
        st_d   = HELD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_VECTOR;
      epc_q  <= '0;
      tgt_q  <= '0;
      pend_q <= 1'b0;
      rt_q   <= 1'b0;
      st_q   <= RUN;
    end else begin
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      tgt_q  <= tgt_d;
      pend_q <= pend_d;
      rt_q   <= rt_d;
      st_q   <= st_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.pc_plus_4      = pp4;
  assign bus.epc            = epc_q;
  assign bus.redirect_taken = rt_q;
  assign bus.pending        = pend_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed scoreboard bench for pc_next_unit: stimulus queues
// expected PC state, a monitor compares it away from the edge.
module tb_pc_next_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pc_next_unit_if #(.XLEN(32)) bus ();

  pc_next_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0),
    .EXC_VECTOR   (32'h180)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic        rt;
    logic        pend;
    logic        ce;
    logic [31:0] epc;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;
  event mon_ev;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or mon_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, ".pc"}, bus.pc, e.pc);
        chk({e.nm, ".pc_plus_4"}, bus.pc_plus_4, e.pc + 32'd4);
        chk({e.nm, ".redirect_taken"},
            32'(bus.redirect_taken), 32'(e.rt));
        chk({e.nm, ".pending"}, 32'(bus.pending), 32'(e.pend));
        if (e.ce) chk({e.nm, ".epc"}, bus.epc, e.epc);
      end
    end
  end

  task automatic push(input string nm, input logic [31:0] pc,
                      input logic rt, input logic pend,
                      input logic ce = 1'b0,
                      input logic [31:0] epc = 32'h0);
    exp_t e;
    e.nm = nm; e.pc = pc; e.rt = rt;
    e.pend = pend; e.ce = ce; e.epc = epc;
    q.push_back(e);
  endtask

  task automatic cyc(input string nm, input logic [31:0] pc,
                     input logic rt, input logic pend,
                     input logic ce = 1'b0,
                     input logic [31:0] epc = 32'h0);
    @(posedge clk);
    #1;
    push(nm, pc, rt, pend, ce, epc);
  endtask

  task automatic clr();
    bus.stall       = 1'b0;
    bus.branch      = 1'b0;
    bus.branch_ne   = 1'b0;
    bus.zero        = 1'b0;
    bus.imm_ext     = 32'h0;
    bus.jump        = 1'b0;
    bus.jump_target = 26'h0;
    bus.jump_reg    = 1'b0;
    bus.rs_value    = 32'h0;
    bus.exception   = 1'b0;
  endtask

  task automatic go_jr(input string nm, input logic [31:0] a);
    clr();
    bus.jump_reg = 1'b1;
    bus.rs_value = a;
    cyc(nm, a, 1'b1, 1'b0);
    clr();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : stim
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;
    push("reset", 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    cyc("seq1", 32'd4, 1'b0, 1'b0);
    cyc("seq2", 32'd8, 1'b0, 1'b0);
    cyc("seq3", 32'd12, 1'b0, 1'b0);

    // BEQ taken, BNE not taken, BNE taken
    go_jr("jr_100a", 32'h100);
    bus.branch = 1'b1; bus.zero = 1'b1;
    bus.imm_ext = 32'hFFFF_FFFE;
    cyc("beq_taken", 32'hFC, 1'b1, 1'b0);
    go_jr("jr_100b", 32'h100);
    bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_ne = 1'b1;
    bus.imm_ext = 32'hFFFF_FFFE;
    cyc("bne_not_taken", 32'h104, 1'b0, 1'b0);
    bus.zero = 1'b0;
    cyc("bne_taken", 32'h100, 1'b1, 1'b0);

    // jump_reg over jump, jump over branch
    go_jr("jr_4k", 32'h4000_0010);
    bus.jump = 1'b1; bus.jump_target = 26'h40;
    bus.jump_reg = 1'b1; bus.rs_value = 32'h2003;
    cyc("jr_over_j", 32'h2000, 1'b1, 1'b0);
    go_jr("jr_4k_b", 32'h4000_0010);
    bus.jump = 1'b1; bus.jump_target = 26'h40;
    bus.branch = 1'b1; bus.zero = 1'b1;
    cyc("j_over_br", 32'h4000_0100, 1'b1, 1'b0);

    // stall buffering
    go_jr("jr_20", 32'h20);
    bus.stall = 1'b1; bus.jump = 1'b1;
    bus.jump_target = 26'h100;
    cyc("stall_buf", 32'h20, 1'b0, 1'b1);
    bus.jump = 1'b0; bus.zero = 1'b1; bus.imm_ext = 32'h10;
    bus.branch = 1'b1;
    cyc("held1", 32'h20, 1'b0, 1'b1);
    bus.branch = 1'b0;
    cyc("held2", 32'h20, 1'b0, 1'b1);
    bus.branch = 1'b1;
    cyc("held3", 32'h20, 1'b0, 1'b1);
    clr();
    cyc("release", 32'h400, 1'b1, 1'b0);

    // exception over pending
    go_jr("jr_20b", 32'h20);
    bus.stall = 1'b1; bus.jump = 1'b1;
    bus.jump_target = 26'h100;
    cyc("stall_buf2", 32'h20, 1'b0, 1'b1);
    bus.exception = 1'b1;
    cyc("exc", 32'h180, 1'b1, 1'b0, 1'b1, 32'h20);
    clr();
    bus.stall = 1'b1;
    cyc("exc_hold", 32'h180, 1'b0, 1'b0);
    bus.stall = 1'b0;
    cyc("exc_seq", 32'h184, 1'b0, 1'b0, 1'b1, 32'h20);

    // wrap, then async reset while HELD
    go_jr("jr_top", 32'hFFFF_FFFC);
    cyc("wrap", 32'h0, 1'b0, 1'b0);
    go_jr("jr_40", 32'h40);
    bus.stall = 1'b1; bus.jump = 1'b1;
    bus.jump_target = 26'h100;
    cyc("held_pre_rst", 32'h40, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    push("async_rst", 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    -> mon_ev;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    cyc("post_rst", 32'h4, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain actual=%0d required=0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
